// File: rtl/gpio_button_scheduler.sv
// rtl/gpio_button_scheduler.sv - debounced N-button event scheduler with round-robin event port
//
// Purpose: synchronises and debounces N_BTN active-low push buttons on a shared
// sample tick, queues press/release events per channel, and serialises them onto
// one valid/ready event port through a round-robin arbiter.
//
// Ports:
//   src_clk     - system clock
//   rst         - asynchronous reset, active-high
//   pb_n        - raw buttons, active-low, asynchronous to src_clk
//   evt_ready   - consumer accepts the current event
//   ovr_clr     - single-cycle clear of evt_overrun
//   evt_valid   - event present on evt_id/evt_press
//   evt_id      - button index of the event
//   evt_press   - 1 = press event, 0 = release event
//   btn_level   - debounced level per button (1 = pressed)
//   evt_overrun - sticky flag, set when an event is lost

module gpio_button_scheduler #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 5208,
    parameter int STABLE_CNT = 4,
    parameter int ID_W       = $clog2(N_BTN)
) (
    input  logic              src_clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  pb_n,
    input  logic              evt_ready,
    input  logic              ovr_clr,
    output logic              evt_valid,
    output logic [ID_W-1:0]   evt_id,
    output logic              evt_press,
    output logic [N_BTN-1:0]  btn_level,
    output logic              evt_overrun
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Two-flop synchroniser; reset to 1 so buttons start released.
    logic [N_BTN-1:0]  sync1_q, sync2_q;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    logic [3:0]        stab_cnt_q [N_BTN];
    logic [3:0]        stab_cnt_d [N_BTN];
    logic [N_BTN-1:0]  level_q, level_d;
    logic [N_BTN-1:0]  set_press, set_rel;

    logic [N_BTN-1:0]  press_pend_q, press_pend_d;
    logic [N_BTN-1:0]  rel_pend_q, rel_pend_d;
    logic [N_BTN-1:0]  clr_press, clr_rel;
    logic [N_BTN-1:0]  req;
    logic              any_pend;

    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   grant_id;
    logic              grant_press;
    logic              load;

    logic [ID_W-1:0]   evt_id_q, evt_id_d;
    logic              evt_press_q, evt_press_d;
    logic              overrun_q, overrun_d;
    logic              ovr_set;

    state_t            state_q, state_d;

    // Sample tick generator.
    always_comb begin
        tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Per-channel debounce: a toggle needs STABLE_CNT consecutive differing
    // ticks, so the toggle fires when the counter already holds STABLE_CNT-1.
    always_comb begin
        level_d   = level_q;
        set_press = '0;
        set_rel   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            stab_cnt_d[i] = stab_cnt_q[i];
            if (tick) begin
                if (!sync2_q[i] == level_q[i]) begin
                    stab_cnt_d[i] = '0;
                end else if (stab_cnt_q[i] == 4'(STABLE_CNT - 1)) begin
                    stab_cnt_d[i] = '0;
                    level_d[i]    = ~level_q[i];
                    set_press[i]  = ~level_q[i];
                    set_rel[i]    = level_q[i];
                end else begin
                    stab_cnt_d[i] = stab_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int  idx;
        logic found;
        req      = press_pend_q | rel_pend_q;
        any_pend = |req;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = (int'(rr_q) + k) % N_BTN;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
        // Press is served before release within one channel.
        grant_press = press_pend_q[grant_id];
    end

    // Output stage FSM: state register.
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output stage FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (any_pend) state_d = ST_FULL;
            ST_FULL:  if (evt_ready && !any_pend) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Output stage FSM: outputs.
    always_comb begin
        evt_valid = (state_q == ST_FULL);
        load      = any_pend && ((state_q == ST_EMPTY) || evt_ready);
    end

    // Event register load, pending-flag update and overrun detection.
    always_comb begin
        rr_d        = rr_q;
        evt_id_d    = evt_id_q;
        evt_press_d = evt_press_q;
        clr_press   = '0;
        clr_rel     = '0;
        if (load) begin
            evt_id_d    = grant_id;
            evt_press_d = grant_press;
            rr_d        = grant_id;
            if (grant_press) begin
                clr_press[grant_id] = 1'b1;
            end else begin
                clr_rel[grant_id] = 1'b1;
            end
        end
        // Set after clear so a same-edge set wins over the grant clear.
        press_pend_d = (press_pend_q & ~clr_press) | set_press;
        rel_pend_d   = (rel_pend_q & ~clr_rel) | set_rel;
        // A flag being consumed this edge can absorb a new set without loss.
        ovr_set   = |((press_pend_q & ~clr_press & set_press) |
                      (rel_pend_q & ~clr_rel & set_rel));
        overrun_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            tick_cnt_q   <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                stab_cnt_q[i] <= '0;
            end
            level_q      <= '0;
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            rr_q         <= ID_W'(N_BTN - 1);
            evt_id_q     <= '0;
            evt_press_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= pb_n;
            sync2_q      <= sync1_q;
            tick_cnt_q   <= tick_cnt_d;
            for (int i = 0; i < N_BTN; i++) begin
                stab_cnt_q[i] <= stab_cnt_d[i];
            end
            level_q      <= level_d;
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            rr_q         <= rr_d;
            evt_id_q     <= evt_id_d;
            evt_press_q  <= evt_press_d;
            overrun_q    <= overrun_d;
        end
    end

    assign evt_id      = evt_id_q;
    assign evt_press   = evt_press_q;
    assign btn_level   = level_q;
    assign evt_overrun = overrun_q;

endmodule
